mine_board_ctrl: RTL and testbench

Game controller and cell-state owner for the 16x16 Minesweeper board. It consumes the cursor position and the one-cycle select/flag pulses from the cursor block. It places mines on the first select, avoiding the selected cell, and sequences each reveal (8-cycle neighbour count scan). It tracks flags, win and loss, and serves a registered read port to the pixel renderer.

---
 rtl/mine_board_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mine_board_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mine_board_ctrl.sv
// Minesweeper 16x16 board controller. It owns the cell state, places the mines
// on the first reveal, sequences each reveal with a neighbour count scan, and
// tracks flags, win and loss. It also serves a registered read port for the renderer.
module mine_board_ctrl #(
    parameter int unsigned NUM_MINES = 40,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] cursor_x,
    input  logic [5:0] cursor_y,
    input  logic       sel_sqr,
    input  logic       place_flag,
    input  logic       new_game,
    input  logic [3:0] rd_x,
    input  logic [3:0] rd_y,
    output logic [6:0] rd_cell,
    output logic       busy,
    output logic       lost,
    output logic       won,
    output logic [7:0] flags_left
);

    localparam int unsigned NUM_CELLS = 256;
    localparam int unsigned CELL_W    = 7;
    localparam int unsigned MINE_B    = 6;
    localparam int unsigned REV_B     = 5;
    localparam int unsigned FLAG_B    = 4;
    localparam logic [7:0]  MINES_8   = 8'(NUM_MINES);
    localparam logic [8:0]  WIN_CNT   = 9'(NUM_CELLS - NUM_MINES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLACE,
        S_PLAY,
        S_REVEAL,
        S_COUNT,
        S_WRITE,
        S_WON,
        S_LOST
    } state_t;

    state_t              state;
    logic [CELL_W-1:0]   cells [NUM_CELLS];
    logic [15:0]         lfsr;
    logic [7:0]          target;
    logic [7:0]          placed;
    logic [2:0]          nidx;
    logic [3:0]          acc;
    logic [8:0]          revealed_cnt;

    logic                cursor_ok_c;
    logic [7:0]          cur_idx_c;
    logic [7:0]          cand_c;
    logic                lfsr_fb_c;
    logic [CELL_W-1:0]   tgt_cell_c;
    logic [CELL_W-1:0]   cur_cell_c;
    logic [4:0]          dx_c;
    logic [4:0]          dy_c;
    logic [4:0]          nx_c;
    logic [4:0]          ny_c;
    logic                nb_mine_c;

    // Status flags are pure decodes of the state register
    assign busy = (state == S_PLACE) || (state == S_REVEAL) ||
                  (state == S_COUNT) || (state == S_WRITE);
    assign lost = (state == S_LOST);
    assign won  = (state == S_WON);

    // Cursor validity, placement candidate and LFSR feedback (taps 16,14,13,11)
    always_comb begin
        cursor_ok_c = (cursor_x[5:4] == 2'b00) && (cursor_y[5:4] == 2'b00);
        cur_idx_c   = {cursor_y[3:0], cursor_x[3:0]};
        cand_c      = lfsr[7:0];
        lfsr_fb_c   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        tgt_cell_c  = cells[target];
        cur_cell_c  = cells[cur_idx_c];
    end

    // Neighbour under scan; a coordinate of -1 or 16 sets bit 4 and is rejected
    always_comb begin
        dx_c = 5'd0;
        dy_c = 5'd0;
        case (nidx)
            3'd0: begin dx_c = 5'h1f; dy_c = 5'h1f; end
            3'd1: begin dx_c = 5'd0;  dy_c = 5'h1f; end
            3'd2: begin dx_c = 5'd1;  dy_c = 5'h1f; end
            3'd3: begin dx_c = 5'h1f; dy_c = 5'd0;  end
            3'd4: begin dx_c = 5'd1;  dy_c = 5'd0;  end
            3'd5: begin dx_c = 5'h1f; dy_c = 5'd1;  end
            3'd6: begin dx_c = 5'd0;  dy_c = 5'd1;  end
            3'd7: begin dx_c = 5'd1;  dy_c = 5'd1;  end
        endcase
        nx_c      = 5'(target[3:0]) + dx_c;
        ny_c      = 5'(target[7:4]) + dy_c;
        nb_mine_c = !nx_c[4] && !ny_c[4] && cells[{ny_c[3:0], nx_c[3:0]}][MINE_B];
    end

    // Game FSM, cell storage, counters and registered read port
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CELLS; i++) cells[i] <= '0;
            state        <= S_IDLE;
            lfsr         <= LFSR_SEED;
            rd_cell      <= '0;
            flags_left   <= MINES_8;
            revealed_cnt <= '0;
            placed       <= '0;
            target       <= '0;
            nidx         <= '0;
            acc          <= '0;
        end else begin
            rd_cell <= cells[{rd_y, rd_x}];
            if (new_game) begin
                for (int i = 0; i < NUM_CELLS; i++) cells[i] <= '0;
                state        <= S_IDLE;
                flags_left   <= MINES_8;
                revealed_cnt <= '0;
                placed       <= '0;
                target       <= '0;
                nidx         <= '0;
                acc          <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (sel_sqr && cursor_ok_c) begin
                            target <= cur_idx_c;
                            placed <= '0;
                            state  <= S_PLACE;
                        end
                    end
                    S_PLACE: begin
                        lfsr <= {lfsr[14:0], lfsr_fb_c};
                        if (!cells[cand_c][MINE_B] && (cand_c != target)) begin
                            cells[cand_c][MINE_B] <= 1'b1;
                            placed                <= placed + 8'd1;
                            if (placed + 8'd1 == MINES_8) state <= S_REVEAL;
                        end
                    end
                    S_PLAY: begin
                        if (sel_sqr && cursor_ok_c) begin
                            target <= cur_idx_c;
                            state  <= S_REVEAL;
                        end else if (place_flag && cursor_ok_c && !cur_cell_c[REV_B]) begin
                            if (cur_cell_c[FLAG_B]) begin
                                cells[cur_idx_c][FLAG_B] <= 1'b0;
                                flags_left               <= flags_left + 8'd1;
                            end else if (flags_left != 8'd0) begin
                                cells[cur_idx_c][FLAG_B] <= 1'b1;
                                flags_left               <= flags_left - 8'd1;
                            end
                        end
                    end
                    S_REVEAL: begin
                        if (tgt_cell_c[FLAG_B] || tgt_cell_c[REV_B]) begin
                            state <= S_PLAY;
                        end else if (tgt_cell_c[MINE_B]) begin
                            cells[target][REV_B] <= 1'b1;
                            state                <= S_LOST;
                        end else begin
                            nidx  <= '0;
                            acc   <= '0;
                            state <= S_COUNT;
                        end
                    end
                    S_COUNT: begin
                        if (nb_mine_c) acc <= acc + 4'd1;
                        nidx <= nidx + 3'd1;
                        if (nidx == 3'd7) state <= S_WRITE;
                    end
                    S_WRITE: begin
                        cells[target] <= {tgt_cell_c[MINE_B], 1'b1, 1'b0, acc};
                        revealed_cnt  <= revealed_cnt + 9'd1;
                        if (revealed_cnt + 9'd1 == WIN_CNT) state <= S_WON;
                        else                                state <= S_PLAY;
                    end
                    default: begin
                        // WON and LOST hold until new_game or reset
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mine_board_ctrl.sv
// Self-checking bench for mine_board_ctrl: directed steps plus randomized play
// compared against a board-level model of the game rules.
module tb_mine_board_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] cx, cy;
    logic       sel, flag, ng;
    logic [3:0] rdx, rdy;
    logic [6:0] rd_cell;
    logic       busy, lost, won;
    logic [7:0] flags_left;

    logic [5:0] b_cx, b_cy;
    logic       b_sel, b_flag, b_ng;
    logic [3:0] b_rdx, b_rdy;
    logic [6:0] b_rd_cell;
    logic       b_busy, b_lost, b_won;
    logic [7:0] b_flags_left;

    always #5 clk = ~clk;

    mine_board_ctrl #(.NUM_MINES(40), .LFSR_SEED(16'hACE1)) u_dut (
        .clk(clk), .rst(rst), .cursor_x(cx), .cursor_y(cy), .sel_sqr(sel),
        .place_flag(flag), .new_game(ng), .rd_x(rdx), .rd_y(rdy),
        .rd_cell(rd_cell), .busy(busy), .lost(lost), .won(won),
        .flags_left(flags_left)
    );

    mine_board_ctrl #(.NUM_MINES(255), .LFSR_SEED(16'hACE1)) u_dut255 (
        .clk(clk), .rst(rst), .cursor_x(b_cx), .cursor_y(b_cy), .sel_sqr(b_sel),
        .place_flag(b_flag), .new_game(b_ng), .rd_x(b_rdx), .rd_y(b_rdy),
        .rd_cell(b_rd_cell), .busy(b_busy), .lost(b_lost), .won(b_won),
        .flags_left(b_flags_left)
    );

    int tests  = 0;
    int failed = 0;

    // Board model
    bit m_mine [256];
    bit m_rev  [256];
    bit m_flag [256];
    int m_cnt  [256];
    int m_fl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nbr_count(input int idx);
        int x = idx % 16;
        int y = idx / 16;
        int c = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < 16 &&
                    y + dy >= 0 && y + dy < 16 && m_mine[(y + dy) * 16 + x + dx])
                    c++;
        return c;
    endfunction

    function automatic logic [6:0] exp_cell(input int i);
        return {m_mine[i], m_rev[i], m_flag[i], 4'(m_cnt[i])};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) begin
            m_mine[i] = 0; m_rev[i] = 0; m_flag[i] = 0; m_cnt[i] = 0;
        end
        m_fl = 40;
    endtask

    task automatic pulse(input int x, input int y, input bit s, input bit f);
        @(negedge clk);
        cx = 6'(x); cy = 6'(y); sel = s; flag = f;
        @(negedge clk);
        sel = 1'b0; flag = 1'b0;
    endtask

    task automatic pulse_ng();
        @(negedge clk);
        ng = 1'b1;
        @(negedge clk);
        ng = 1'b0;
    endtask

    task automatic wait_busy(input int budget, output int n);
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic rd(input int idx, output logic [6:0] v);
        @(negedge clk);
        rdx = 4'(idx % 16); rdy = 4'(idx / 16);
        @(negedge clk);
        v = rd_cell;
    endtask

    task automatic check_board(input string tag);
        logic [6:0] v;
        for (int i = 0; i < 256; i++) begin
            rd(i, v);
            check($sformatf("%s[%0d]", tag, i), 32'(v), 32'(exp_cell(i)));
        end
    endtask

    // First reveal of a game: wait out placement, learn the layout, check the target
    task automatic first_click(input int x, input int y);
        logic [6:0] v;
        int n, mines, t;
        t = y * 16 + x;
        pulse(x, y, 1'b1, 1'b0);
        check("busy_rise", 32'(busy), 32'd1);
        wait_busy(30000, n);
        check("place_done", 32'(busy), 32'd0);
        mines = 0;
        for (int i = 0; i < 256; i++) begin
            rd(i, v);
            m_mine[i] = v[6];
            if (v[6]) mines++;
        end
        check("mine_total", 32'(mines), 32'd40);
        check("target_not_mined", 32'(m_mine[t]), 32'd0);
        m_rev[t] = 1;
        m_cnt[t] = nbr_count(t);
        rd(t, v);
        check("target_cell", 32'(v), 32'(exp_cell(t)));
    endtask

    function automatic int find_cell(input bit want_mine);
        int s = int'($urandom_range(0, 255));
        for (int k = 0; k < 256; k++) begin
            int i = (s + k) % 256;
            if (m_mine[i] == want_mine && !m_rev[i] && !m_flag[i]) return i;
        end
        return 0;
    endfunction

    initial begin
        logic [6:0] v;
        int n, idx, op, exp_n, fl0;

        rst = 1'b0; sel = 0; flag = 0; ng = 0; cx = 0; cy = 0; rdx = 0; rdy = 0;
        b_sel = 0; b_flag = 0; b_ng = 0; b_cx = 0; b_cy = 0; b_rdx = 0; b_rdy = 0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_lost", 32'(lost), 32'd0);
        check("rst_won", 32'(won), 32'd0);
        check("rst_flags_left", 32'(flags_left), 32'd40);
        check("rst_rd_cell", 32'(rd_cell), 32'd0);
        rst = 1'b1;
        model_clear();
        check_board("rst_board");

        // IDLE ignores flags
        pulse(2, 2, 1'b0, 1'b1);
        check("idle_flag_busy", 32'(busy), 32'd0);
        check("idle_flag_left", 32'(flags_left), 32'd40);

        // First click at x=3,y=5
        first_click(3, 5);

        // Flag toggling at (0,0), then reveal of a flagged cell
        pulse(0, 0, 1'b0, 1'b1);
        m_flag[0] = 1; m_fl--;
        check("flag_set_left", 32'(flags_left), 32'd39);
        rd(0, v);
        check("flag_set_cell", 32'(v), 32'(exp_cell(0)));
        pulse(0, 0, 1'b0, 1'b1);
        m_flag[0] = 0; m_fl++;
        check("flag_clr_left", 32'(flags_left), 32'd40);
        rd(0, v);
        check("flag_clr_cell", 32'(v), 32'(exp_cell(0)));
        pulse(0, 0, 1'b0, 1'b1);
        m_flag[0] = 1; m_fl--;
        pulse(0, 0, 1'b1, 1'b0);
        wait_busy(50, n);
        check("flagged_reveal_busy", 32'(n), 32'd1);
        rd(0, v);
        check("flagged_reveal_cell", 32'(v), 32'(exp_cell(0)));

        // Invalid cursor pulses are dropped
        pulse(16, 2, 1'b1, 1'b0);
        check("bad_x_sel", 32'(busy), 32'd0);
        pulse(3, 20, 1'b0, 1'b1);
        check("bad_y_flag", 32'(flags_left), 32'(m_fl));

        // Randomized play against the model (mines are flagged, never revealed)
        for (int k = 0; k < 40; k++) begin
            idx = int'($urandom_range(0, 255));
            op  = int'($urandom_range(0, 2));
            if (op != 0 && m_mine[idx] && !m_flag[idx] && !m_rev[idx]) op = 0;
            if (op == 0) begin
                pulse(idx % 16, idx / 16, 1'b0, 1'b1);
                if (!m_rev[idx]) begin
                    if (m_flag[idx]) begin m_flag[idx] = 0; m_fl++; end
                    else if (m_fl > 0) begin m_flag[idx] = 1; m_fl--; end
                end
                check($sformatf("rnd_flag_left_%0d", k), 32'(flags_left), 32'(m_fl));
            end else begin
                exp_n = (m_flag[idx] || m_rev[idx]) ? 1 : 10;
                pulse(idx % 16, idx / 16, 1'b1, 1'b0);
                wait_busy(50, n);
                check($sformatf("rnd_sel_busy_%0d", k), 32'(n), 32'(exp_n));
                if (exp_n == 10) begin
                    m_rev[idx] = 1;
                    m_cnt[idx] = nbr_count(idx);
                end
            end
        end
        check_board("rnd_board");

        // new_game in the middle of the neighbour scan
        idx = find_cell(1'b0);
        pulse(idx % 16, idx / 16, 1'b1, 1'b0);
        @(negedge clk);
        check("mid_scan_busy", 32'(busy), 32'd1);
        ng = 1'b1;
        @(negedge clk);
        ng = 1'b0;
        check("ng_busy", 32'(busy), 32'd0);
        check("ng_flags_left", 32'(flags_left), 32'd40);
        model_clear();
        pulse(1, 1, 1'b0, 1'b1);
        check("ng_idle_flag", 32'(flags_left), 32'd40);
        check_board("ng_board");

        // New game: simultaneous reveal and flag only reveals
        first_click(8, 8);
        idx = find_cell(1'b0);
        fl0 = m_fl;
        pulse(idx % 16, idx / 16, 1'b1, 1'b1);
        wait_busy(50, n);
        check("both_busy", 32'(n), 32'd10);
        m_rev[idx] = 1;
        m_cnt[idx] = nbr_count(idx);
        rd(idx, v);
        check("both_cell", 32'(v), 32'(exp_cell(idx)));
        check("both_flags_left", 32'(flags_left), 32'(fl0));

        // Reveal a mine
        idx = find_cell(1'b1);
        pulse(idx % 16, idx / 16, 1'b1, 1'b0);
        wait_busy(50, n);
        check("lose_busy", 32'(n), 32'd1);
        check("lose_lost", 32'(lost), 32'd1);
        m_rev[idx] = 1;
        rd(idx, v);
        check("lose_cell", 32'(v), 32'h60);
        idx = find_cell(1'b0);
        pulse(idx % 16, idx / 16, 1'b1, 1'b0);
        check("lost_sel_busy", 32'(busy), 32'd0);
        pulse(idx % 16, idx / 16, 1'b0, 1'b1);
        check("lost_flag_left", 32'(flags_left), 32'(m_fl));
        check("lost_hold", 32'(lost), 32'd1);
        check_board("lost_board");
        pulse_ng();
        check("ng2_lost", 32'(lost), 32'd0);
        check("ng2_busy", 32'(busy), 32'd0);
        model_clear();
        check_board("ng2_board");

        // 255-mine board: first reveal wins immediately
        check("b_flags_left", 32'(b_flags_left), 32'd255);
        @(negedge clk);
        b_cx = 6'd7; b_cy = 6'd7; b_sel = 1'b1;
        @(negedge clk);
        b_sel = 1'b0;
        n = 0;
        while (b_busy === 1'b1 && n < 30000) begin n++; @(negedge clk); end
        check("b_done_77", 32'(b_busy), 32'd0);
        check("b_won_77", 32'(b_won), 32'd1);
        b_rdx = 4'd7; b_rdy = 4'd7;
        repeat (2) @(negedge clk);
        check("b_cell_77", 32'(b_rd_cell), 32'h28);
        @(negedge clk);
        b_ng = 1'b1;
        @(negedge clk);
        b_ng = 1'b0;
        check("b_ng_won", 32'(b_won), 32'd0);
        b_cx = 6'd0; b_cy = 6'd0; b_sel = 1'b1;
        @(negedge clk);
        b_sel = 1'b0;
        n = 0;
        while (b_busy === 1'b1 && n < 30000) begin n++; @(negedge clk); end
        check("b_done_00", 32'(b_busy), 32'd0);
        check("b_won_00", 32'(b_won), 32'd1);
        b_rdx = 4'd0; b_rdy = 4'd0;
        repeat (2) @(negedge clk);
        check("b_cell_00", 32'(b_rd_cell), 32'h23);
        check("b_lost", 32'(b_lost), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
